fetch_unit: RTL and testbench

- Instruction fetch stage, directly upstream of the 256x8 synchronous program memory.
- Owns the program counter and drives the memory address.
- Accounts for the memory's 1-cycle registered read latency and buffers returned bytes in a 2-entry skid FIFO.
- Hands {pc, instr} to decode over a valid/ready handshake; supports redirect (jump/branch) with flush.

---
 rtl/never8_pkg.sv | 14 +
 rtl/fetch_skid_fifo.sv | 51 +++++
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/never8_pkg.sv
// Shared constants and types for the never8 fetch path.
package never8_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;
  localparam logic [DATA_W-1:0] HALT_OPCODE = 8'hFF;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid FIFO between program-memory read data and decode.
// Flush wins over push; an overflowing push trips an assertion.
module fetch_skid_fifo
  import never8_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  entry_t     din,
  input  logic       pop,
  input  logic       flush,
  output logic [1:0] count,
  output entry_t     head
);

  entry_t slot [2];
  logic   rd_ptr;
  logic   wr_ptr;

  assign head = slot[rd_ptr];

  // Storage, pointers and occupancy; flush discards everything buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot[0] <= '0;
      slot[1] <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count   <= '0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        slot[wr_ptr] <= din;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  ovf_chk : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !flush && (count == 2'd2)));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, one-deep read tracking, credit-based issue,
// skid buffering and redirect/flush.
// Optional halt-on-opcode support is enabled by defining FETCH_HALT_EN.
module fetch_unit
  import never8_pkg::*;
#(
  parameter int unsigned ADDR_W = never8_pkg::ADDR_W,
  parameter int unsigned DATA_W = never8_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = never8_pkg::RESET_PC,
  parameter logic [DATA_W-1:0] HALT_OPCODE = never8_pkg::HALT_OPCODE
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              halted
);

`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic              stop;
  logic              pop;
  logic              capture;
  logic              halt_hit;
  logic              issue;
  logic [2:0]        occ;
  logic [1:0]        count;
  entry_t            head;
  entry_t            push_entry;

  assign pop         = instr_valid & instr_ready;
  assign mem_addr    = redirect_valid ? redirect_addr : pc;
  // A redirect kills the read in flight; after a halt push no further data is kept.
  assign capture     = inflight & ~redirect_valid & ~stop;
  assign halt_hit    = HALT_EN & capture & (mem_data == HALT_OPCODE);
  assign occ         = 3'(count) + 3'(inflight);
  // halt_hit blocks the issue in the same cycle the halt byte is pushed,
  // so nothing is left in flight behind it.
  assign issue       = redirect_valid |
                       (~halted & ~stop & ~halt_hit & (occ < (3'd2 + 3'(pop))));
  assign push_entry  = '{pc: inflight_pc, instr: mem_data};
  assign instr_valid = (count != 2'd0);
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

  // Program counter and outstanding-read tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (issue) begin
      inflight    <= 1'b1;
      inflight_pc <= mem_addr;
      pc          <= mem_addr + ADDR_W'(1);
    end else begin
      inflight <= 1'b0;
    end
  end

`ifdef FETCH_HALT_EN
  // Halt tracking: stop on the halt push, report halted once it is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stop   <= 1'b0;
      halted <= 1'b0;
    end else if (redirect_valid) begin
      stop   <= 1'b0;
      halted <= 1'b0;
    end else begin
      if (halt_hit) begin
        stop <= 1'b1;
      end
      if (pop && stop && (head.instr == HALT_OPCODE)) begin
        halted <= 1'b1;
      end
    end
  end
`else
  assign stop   = 1'b0;
  assign halted = 1'b0;
`endif

  fetch_skid_fifo #(
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (capture),
    .din   (push_entry),
    .pop   (pop),
    .flush (redirect_valid),
    .count (count),
    .head  (head)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural program-stream model.
module tb_fetch_unit;

  logic       clk;
  logic       rst_n;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       redirect_valid;
  logic [7:0] redirect_addr;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr;
  logic [7:0] instr_pc;
  logic       halted;

  logic [7:0] mem [256];

  int checks = 0;
  int failures = 0;

  // Model state: next address decode must see, plus hold tracking.
  logic [7:0] exp_pc = 8'h00;
  logic       stall_prev = 1'b0;
  logic [7:0] held_pc;
  logic [7:0] held_instr;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous program memory with one-cycle registered read.
  always @(posedge clk) mem_data <= mem[mem_addr];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  // Stream model: delivered instructions are consecutive addresses from the
  // last reset/redirect, each carrying the program byte at that address.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pc     = 8'h00;
      stall_prev = 1'b0;
      chk("rst_valid", instr_valid, 0);
    end else begin
      if (stall_prev) begin
        chk("hold_valid", instr_valid, 1);
        chk("hold_pc", instr_pc, held_pc);
        chk("hold_instr", instr, held_instr);
      end
      if (instr_valid && instr_ready) begin
        chk("stream_pc", instr_pc, exp_pc);
        chk("stream_instr", instr, mem[exp_pc]);
        exp_pc = exp_pc + 8'd1;
      end
      if (redirect_valid) exp_pc = redirect_addr;
      stall_prev = instr_valid && !instr_ready && !redirect_valid;
      held_pc    = instr_pc;
      held_instr = instr;
`ifndef FETCH_HALT_EN
      chk("halted_tied", halted, 0);
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] wrap_pc [4];
    logic [7:0] wrap_in [4];
    wrap_pc = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    wrap_in = '{8'hEE, 8'h00, 8'h01, 8'h02};

    for (int unsigned i = 0; i < 256; i++) mem[i] = 8'(i + 1);
    mem[254] = 8'hEE;
    rst_n = 1'b0;
    instr_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr = 8'h00;

    // Basic stream after reset: valid two edges after release.
    do_reset();
    sample();
    chk("reset_valid", instr_valid, 0);
    chk("reset_instr", instr, 0);
    chk("reset_pc", instr_pc, 0);
    chk("reset_halted", halted, 0);
    chk("reset_addr", mem_addr, 0);
    next_cycle(); sample();
    chk("lat_edge1_valid", instr_valid, 0);
    next_cycle(); sample();
    chk("first_valid", instr_valid, 1);
    chk("first_pc", instr_pc, 8'h00);
    chk("first_instr", instr, 8'h01);
    next_cycle(); sample();
    chk("second_pc", instr_pc, 8'h01);
    chk("second_instr", instr, 8'h02);
    next_cycle(); sample();
    chk("third_pc", instr_pc, 8'h02);
    chk("third_instr", instr, 8'h03);

    // Backpressure: decode stalls for 5 cycles after the first valid.
    instr_ready = 1'b0;
    do_reset();
    next_cycle();
    next_cycle();
    for (int unsigned i = 0; i < 5; i++) begin
      sample();
      chk("stall_valid", instr_valid, 1);
      chk("stall_pc", instr_pc, 8'h00);
      chk("stall_instr", instr, 8'h01);
      chk("stall_addr", mem_addr, 8'h02);
      next_cycle();
    end
    instr_ready = 1'b1;
    sample();
    chk("resume0_pc", instr_pc, 8'h00);
    next_cycle(); sample();
    chk("resume1_pc", instr_pc, 8'h01);
    next_cycle(); sample();
    chk("resume2_pc", instr_pc, 8'h02);
    next_cycle(); sample();
    chk("resume3_pc", instr_pc, 8'h03);
    chk("resume3_instr", instr, 8'h04);

    // Redirect with two entries buffered and decode stalled.
    next_cycle();
    instr_ready = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();
    redirect_valid = 1'b1;
    redirect_addr = 8'h40;
    sample();
    next_cycle();
    redirect_valid = 1'b0;
    sample();
    chk("redir_bubble", instr_valid, 0);
    next_cycle();
    instr_ready = 1'b1;
    sample();
    chk("redir_target_valid", instr_valid, 1);
    chk("redir_target_pc", instr_pc, 8'h40);
    chk("redir_target_instr", instr, 8'h41);
    next_cycle(); sample();
    chk("redir_next_pc", instr_pc, 8'h41);

    // Redirect during a flowing stream, then wrap past FF.
    next_cycle();
    redirect_valid = 1'b1;
    redirect_addr = 8'hFE;
    sample();
    next_cycle();
    redirect_valid = 1'b0;
    sample();
    chk("wrap_bubble", instr_valid, 0);
    for (int unsigned i = 0; i < 4; i++) begin
      next_cycle(); sample();
      chk("wrap_valid", instr_valid, 1);
      chk("wrap_pc", instr_pc, wrap_pc[i]);
      chk("wrap_instr", instr, wrap_in[i]);
    end

    // Asynchronous reset with a full buffer.
    next_cycle();
    instr_ready = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", instr_valid, 0);
    chk("rst_mid_addr", mem_addr, 8'h00);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    instr_ready = 1'b1;
    next_cycle(); sample();
    chk("rst_mid_lat", instr_valid, 0);
    next_cycle(); sample();
    chk("rst_mid_restart_valid", instr_valid, 1);
    chk("rst_mid_restart_pc", instr_pc, 8'h00);

`ifdef FETCH_HALT_EN
    // Halt on FF at address 3, then redirect clears it.
    next_cycle();
    mem[3] = 8'hFF;
    redirect_valid = 1'b1;
    redirect_addr = 8'h00;
    next_cycle();
    redirect_valid = 1'b0;
    sample();
    chk("halt_bubble", instr_valid, 0);
    for (int unsigned i = 0; i < 4; i++) begin
      next_cycle(); sample();
      chk("halt_seq_valid", instr_valid, 1);
      chk("halt_seq_pc", instr_pc, i);
      chk("halt_seq_halted", halted, 0);
    end
    chk("halt_instr", instr, 8'hFF);
    for (int unsigned i = 0; i < 6; i++) begin
      next_cycle(); sample();
      chk("halted_set", halted, 1);
      chk("halted_no_more", instr_valid, 0);
    end
    mem[3] = 8'h04;
    next_cycle();
    redirect_valid = 1'b1;
    redirect_addr = 8'h00;
    next_cycle();
    redirect_valid = 1'b0;
    sample();
    chk("halt_cleared", halted, 0);
    next_cycle(); sample();
    chk("halt_restart_valid", instr_valid, 1);
    chk("halt_restart_pc", instr_pc, 8'h00);
    next_cycle(); sample();
    chk("halt_restart_next", instr_pc, 8'h01);
`endif

    next_cycle();
    next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
